auldec_md: RTL and testbench
============================

AULDEC_MD -- requirements
Module: aludec_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath and HI/LO width (legal 4..64).
REQ-002 Parameter CTRL_W, default 4, alucontrol width (minimum 4).
REQ-003 Clock and reset: one clock and one reset; reset is asynchronous and active-low.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid  in  1  instruction in decode this cycle.
- funct  in  6  instruction funct field.
- aluop  in  2  main-decoder op class.
- srca  in  WIDTH  rs operand (multiplicand/dividend).
- srcb  in  WIDTH  rt operand (multiplier/divisor).
- alucontrol  out  CTRL_W  ALU operation.
- rdsel  out  2  result source: 00 ALU, 01 HI, 10 LO.
- illegal  out  1  unknown funct with aluop=10.
- stall  out  1  hold decode stage.
- busy  out  1  mult/div sequencer active.
- done  out  1  one-cycle pulse on HI/LO commit.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Function
REQ-005 alucontrol, rdsel and illegal SHALL be combinational from aluop/funct; zero-extended to CTRL_W.
REQ-006 aluop decode: 00 add(0010), 01 sub(0110), 11 or(0001), 10 funct decode.
REQ-007 funct decode: 100000/100001/001001 add(0010); 100010/100011 sub(0110); 100100 and(0000); 100101 or(0001); 100110 xor(0011); 100111 nor(0100); 101010 slt(0111); 101011 sltu(1000).
REQ-008 funct 010000 mfhi sets rdsel=01; 010010 mflo sets rdsel=10; all other cases rdsel=00.
REQ-009 funct 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo: alucontrol=0000, illegal=0.
REQ-010 Any other funct with aluop=10: alucontrol=0000, illegal=1, no state change.
REQ-011 FSM states IDLE, RUN, FIX; busy=1 in RUN and FIX.
REQ-012 Accept: at the edge where state=IDLE, valid=1, aluop=10 and funct is a mult/div code, latch |operands| (signed ops) or raw operands (unsigned ops) and the result signs, clear the counter, go to RUN.
REQ-013 RUN: one radix-2 shift-add (mult) or restoring shift-subtract (div) step per cycle; after exactly WIDTH steps go to FIX.
REQ-014 FIX: apply sign correction, write hi/lo, set done=1 for that cycle, go to IDLE at the next edge.
REQ-015 Latency: an op accepted at edge k SHALL update hi/lo at edge k+WIDTH+1; busy is high for cycles k+1 through k+WIDTH+1.
REQ-016 mult/multu: {hi,lo} = full 2*WIDTH-bit product.
REQ-017 div/divu: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
REQ-018 Divide by zero: lo = all ones, hi = srca as latched; latency unchanged.
REQ-019 Signed overflow (most-negative / -1): lo = most-negative value, hi = 0.
REQ-020 mthi/mtlo in IDLE: write srca to hi/lo at that edge; no busy, no done.
REQ-021 stall = valid & aluop=10 & (funct is mult/div/mthi/mtlo/mfhi/mflo) & (state!=IDLE); the stalled instruction SHALL have no effect.
REQ-022 hi/lo SHALL hold steady while busy; intermediate values are never visible.
REQ-023 Instructions with aluop!=10, or non-HI/LO R-type instructions, SHALL never stall and SHALL not disturb the sequencer.

Reset
REQ-024 reset_n=0 SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, and counter=0, including mid-operation; the aborted op SHALL leave no result.
REQ-025 After reset_n rises, an op SHALL be accepted at the first qualifying edge.

Verification
REQ-026 aluop=10, funct=101010 -> alucontrol=0111, rdsel=00, illegal=0; funct=111111 -> illegal=1, alucontrol=0000.
REQ-027 WIDTH=32, mult srca=-3, srcb=7 -> after 33 cycles hi=FFFFFFFF, lo=FFFFFFEB, done pulses once, busy deasserts the next cycle.
REQ-028 div srca=-7, srcb=2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu srca=7, srcb=0 -> lo=FFFFFFFF, hi=00000007.
REQ-029 mflo presented 5 cycles after a multu is accepted -> stall=1 until the cycle after FIX, then rdsel=10 and lo holds the product.
REQ-030 reset_n pulsed low at RUN step 10 -> hi=lo=0 and busy=0 immediately, no done; a new mtlo 0x1234 then writes lo=00001234 at one edge.
REQ-031 WIDTH=8, multu 0xFF*0xFF -> hi=FE, lo=01 at edge k+9.

Source files
------------

// File: rtl/auldec_md.sv
// auldec_md: ALU decoder with an attached multi-cycle multiply/divide unit.
// The decoder is purely combinational. The HI/LO sequencer performs one
// radix-2 shift-add or restoring shift-subtract step per cycle on operand
// magnitudes. It applies the sign correction in a final FIX cycle, so HI/LO
// only ever show committed results.
module auldec_md #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid,
  input  logic [5:0]        funct,
  input  logic [1:0]        aluop,
  input  logic [WIDTH-1:0]  srca,
  input  logic [WIDTH-1:0]  srcb,
  output logic [CTRL_W-1:0] alucontrol,
  output logic [1:0]        rdsel,
  output logic              illegal,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  hi,
  output logic [WIDTH-1:0]  lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // Sequencer state
  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   acc_r;     // product high half / partial remainder
  logic [WIDTH-1:0]   low_r;     // multiplier bits / dividend-quotient bits
  logic [WIDTH-1:0]   opnd_r;    // multiplicand / divisor magnitude
  logic               neg_lo_r;  // negate product or quotient at FIX
  logic               neg_hi_r;  // negate remainder at FIX (dividend sign)
  logic               div0_r;    // divisor was zero: quotient forced to all ones
  logic               is_div_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Decode results
  logic [3:0]         alu_s;
  logic               is_muldiv_s;
  logic               is_mthi_s;
  logic               is_mtlo_s;
  logic               is_hilo_s;
  logic               r_type_s;

  // Operand conditioning
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;

  // Step datapath
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     shift_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH-1:0]   acc_nx_s;
  logic [WIDTH-1:0]   low_nx_s;

  // Final correction
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   hi_fix_s;
  logic [WIDTH-1:0]   lo_fix_s;

  // Decode aluop/funct into ALU control, result select and HI/LO op class
  always_comb begin
    alu_s       = 4'b0000;
    rdsel       = 2'b00;
    illegal     = 1'b0;
    is_muldiv_s = 1'b0;
    is_mthi_s   = 1'b0;
    is_mtlo_s   = 1'b0;
    is_hilo_s   = 1'b0;
    case (aluop)
      2'b00: alu_s = 4'b0010;
      2'b01: alu_s = 4'b0110;
      2'b11: alu_s = 4'b0001;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001, 6'b001001: alu_s = 4'b0010;
          6'b100010, 6'b100011:            alu_s = 4'b0110;
          6'b100100:                       alu_s = 4'b0000;
          6'b100101:                       alu_s = 4'b0001;
          6'b100110:                       alu_s = 4'b0011;
          6'b100111:                       alu_s = 4'b0100;
          6'b101010:                       alu_s = 4'b0111;
          6'b101011:                       alu_s = 4'b1000;
          F_MFHI: begin
            rdsel     = 2'b01;
            is_hilo_s = 1'b1;
          end
          F_MFLO: begin
            rdsel     = 2'b10;
            is_hilo_s = 1'b1;
          end
          F_MTHI: begin
            is_mthi_s = 1'b1;
            is_hilo_s = 1'b1;
          end
          F_MTLO: begin
            is_mtlo_s = 1'b1;
            is_hilo_s = 1'b1;
          end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            is_muldiv_s = 1'b1;
            is_hilo_s   = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: alu_s = 4'b0000;
    endcase
  end

  assign alucontrol = CTRL_W'(alu_s);
  assign r_type_s   = valid & (aluop == 2'b10);

  // Any HI/LO instruction must wait while the sequencer owns HI/LO
  always_comb begin
    if (r_type_s && is_hilo_s && (state_r != ST_IDLE)) begin
      stall = 1'b1;
    end else begin
      stall = 1'b0;
    end
  end

  // Operand signs and magnitudes; funct[0]=1 selects the unsigned variants
  always_comb begin
    a_neg_s = ~funct[0] & srca[WIDTH-1];
    b_neg_s = ~funct[0] & srcb[WIDTH-1];
    if (a_neg_s) begin
      a_mag_s = -srca;
    end else begin
      a_mag_s = srca;
    end
    if (b_neg_s) begin
      b_mag_s = -srcb;
    end else begin
      b_mag_s = srcb;
    end
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step
  always_comb begin
    add_s   = {1'b0, acc_r} + {1'b0, opnd_r};
    shift_s = {acc_r, low_r[WIDTH-1]};
    sub_s   = shift_s - {1'b0, opnd_r};
    if (is_div_r) begin
      // A zero divisor always takes the subtract path: quotient all ones,
      // remainder ends up as the dividend magnitude.
      if (!sub_s[WIDTH] || div0_r) begin
        acc_nx_s = sub_s[WIDTH-1:0];
        low_nx_s = {low_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx_s = shift_s[WIDTH-1:0];
        low_nx_s = {low_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (low_r[0]) begin
        acc_nx_s = add_s[WIDTH:1];
        low_nx_s = {add_s[0], low_r[WIDTH-1:1]};
      end else begin
        acc_nx_s = {1'b0, acc_r[WIDTH-1:1]};
        low_nx_s = {acc_r[0], low_r[WIDTH-1:1]};
      end
    end
  end

  // Sign correction of the unsigned magnitude result
  always_comb begin
    prod_s = {acc_r, low_r};
    if (neg_lo_r) begin
      prod_fix_s = -prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    if (!is_div_r) begin
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end else begin
      if (neg_hi_r) begin
        hi_fix_s = -acc_r;
      end else begin
        hi_fix_s = acc_r;
      end
      if (div0_r) begin
        lo_fix_s = '1;
      end else if (neg_lo_r) begin
        lo_fix_s = -low_r;
      end else begin
        lo_fix_s = low_r;
      end
    end
  end

  // Sequencer FSM with HI/LO, busy and done registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      low_r    <= '0;
      opnd_r   <= '0;
      neg_lo_r <= 1'b0;
      neg_hi_r <= 1'b0;
      div0_r   <= 1'b0;
      is_div_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (r_type_s && is_muldiv_s) begin
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
            cnt_r    <= '0;
            acc_r    <= '0;
            is_div_r <= funct[1];
            neg_lo_r <= a_neg_s ^ b_neg_s;
            if (funct[1]) begin
              low_r    <= a_mag_s;
              opnd_r   <= b_mag_s;
              neg_hi_r <= a_neg_s;
              div0_r   <= (srcb == '0);
            end else begin
              low_r    <= b_mag_s;
              opnd_r   <= a_mag_s;
              neg_hi_r <= a_neg_s ^ b_neg_s;
              div0_r   <= 1'b0;
            end
          end else if (r_type_s && is_mthi_s) begin
            hi_r <= srca;
          end else if (r_type_s && is_mtlo_s) begin
            lo_r <= srca;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r <= acc_nx_s;
          low_r <= low_nx_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(WIDTH - 1)) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_FIX: begin
          hi_r    <= hi_fix_s;
          lo_r    <= lo_fix_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_auldec_md.sv
// Randomized self-checking bench for auldec_md (WIDTH=32 and WIDTH=8 instances)
// against an arithmetic reference model of HI/LO and the decode table.
module tb_auldec_md;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid, valid8;
  logic [5:0]  funct;
  logic [1:0]  aluop;
  logic [31:0] srca, srcb;
  logic [7:0]  srca8, srcb8;

  logic [3:0]  alucontrol, alucontrol8;
  logic [1:0]  rdsel, rdsel8;
  logic        illegal, illegal8, stall, stall8, busy, busy8, done, done8;
  logic [31:0] hi, lo;
  logic [7:0]  hi8, lo8;

  bit          sel8 = 1'b0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o, stall_o;
  logic [1:0]  rdsel_o;

  logic [31:0] mh [2];
  logic [31:0] ml [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  auldec_md #(.WIDTH(32), .CTRL_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .funct(funct), .aluop(aluop),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .rdsel(rdsel),
    .illegal(illegal), .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  auldec_md #(.WIDTH(8), .CTRL_W(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .valid(valid8), .funct(funct), .aluop(aluop),
    .srca(srca8), .srcb(srcb8), .alucontrol(alucontrol8), .rdsel(rdsel8),
    .illegal(illegal8), .stall(stall8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  assign hi_o    = sel8 ? {24'd0, hi8} : hi;
  assign lo_o    = sel8 ? {24'd0, lo8} : lo;
  assign busy_o  = sel8 ? busy8 : busy;
  assign done_o  = sel8 ? done8 : done;
  assign stall_o = sel8 ? stall8 : stall;
  assign rdsel_o = sel8 ? rdsel8 : rdsel;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_muldiv(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  function automatic bit is_hilo(input logic [5:0] f);
    return is_muldiv(f) || (f == F_MTHI) || (f == F_MTLO) || (f == F_MFHI) || (f == F_MFLO);
  endfunction

  // Decode table: {alucontrol, rdsel, illegal}
  function automatic logic [6:0] dec_model(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return {4'b0010, 2'b00, 1'b0};
    if (op == 2'b01) return {4'b0110, 2'b00, 1'b0};
    if (op == 2'b11) return {4'b0001, 2'b00, 1'b0};
    if (f == 6'b100000 || f == 6'b100001 || f == 6'b001001) return {4'b0010, 2'b00, 1'b0};
    if (f == 6'b100010 || f == 6'b100011) return {4'b0110, 2'b00, 1'b0};
    if (f == 6'b100100) return {4'b0000, 2'b00, 1'b0};
    if (f == 6'b100101) return {4'b0001, 2'b00, 1'b0};
    if (f == 6'b100110) return {4'b0011, 2'b00, 1'b0};
    if (f == 6'b100111) return {4'b0100, 2'b00, 1'b0};
    if (f == 6'b101010) return {4'b0111, 2'b00, 1'b0};
    if (f == 6'b101011) return {4'b1000, 2'b00, 1'b0};
    if (f == F_MFHI) return {4'b0000, 2'b01, 1'b0};
    if (f == F_MFLO) return {4'b0000, 2'b10, 1'b0};
    if (is_hilo(f)) return {4'b0000, 2'b00, 1'b0};
    return {4'b0000, 2'b00, 1'b1};
  endfunction

  // Reference HI/LO result of one instruction at width w, returned as {hi, lo}
  function automatic logic [63:0] model(input int w, input logic [5:0] f,
                                        input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] oh, input logic [31:0] ol);
    logic [63:0] mask, ua, ub, p, h, l;
    longint sa, sb, sp, sq, sr;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    h = {32'd0, oh};
    l = {32'd0, ol};
    case (f)
      F_MULT: begin
        sp = sa * sb;
        p  = sp;
        h  = (p >> w) & mask;
        l  = p & mask;
      end
      F_MULTU: begin
        p = ua * ub;
        h = (p >> w) & mask;
        l = p & mask;
      end
      F_DIV: begin
        if (sb == 0) begin
          h = ua;
          l = mask;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          h = sr;
          h = h & mask;
          l = sq;
          l = l & mask;
        end
      end
      F_DIVU: begin
        if (ub == 64'd0) begin
          h = ua;
          l = mask;
        end else begin
          h = ua % ub;
          l = ua / ub;
        end
      end
      F_MTHI: h = ua;
      F_MTLO: l = ua;
      default: h = {32'd0, oh};
    endcase
    return {h[31:0], l[31:0]};
  endfunction

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    valid  = sel8 ? 1'b0 : v;
    valid8 = sel8 ? v : 1'b0;
    aluop  = op;
    funct  = f;
    srca   = a;
    srcb   = b;
    srca8  = a[7:0];
    srcb8  = b[7:0];
  endtask

  // Issue one HI/LO-writing instruction from IDLE and follow it to completion.
  // mode 0: quiet; 1: random instructions while busy; 2: mflo from 5 cycles after accept.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int mode);
    int w, idx, kind;
    logic [63:0] res;
    logic [31:0] oh, ol;
    logic iv, exp_stall;
    logic [1:0] iop;
    logic [5:0] ifn;
    w   = sel8 ? 8 : 32;
    idx = sel8 ? 1 : 0;
    oh  = mh[idx];
    ol  = ml[idx];
    res = model(w, f, a, b, oh, ol);
    drive(1'b1, 2'b10, f, a, b);
    @(negedge clk);
    if (!is_muldiv(f)) begin
      check_val("mt_hilo", {hi_o, lo_o}, res);
      check_val("mt_flags", {busy_o, done_o}, 2'b00);
      drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    end else begin
      for (int i = 0; i <= w; i++) begin
        check_val("hold", {hi_o, lo_o}, {oh, ol});
        check_val("busy", {busy_o, done_o}, 2'b10);
        iv = 1'b0; iop = 2'b00; ifn = 6'd0;
        if (mode == 1) begin
          kind = $urandom_range(0, 4);
          iv = 1'b1; iop = 2'b10;
          case (kind)
            0: ifn = {4'b0110, 2'($urandom_range(0, 3))};
            1: ifn = ($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO;
            2: ifn = ($urandom_range(0, 1) == 0) ? F_MFHI : F_MFLO;
            3: begin
              ifn = 6'($urandom_range(0, 63));
              iop = 2'($urandom_range(0, 3));
            end
            default: begin
              iv  = 1'b0;
              ifn = 6'($urandom_range(0, 63));
            end
          endcase
        end else if (mode == 2 && i >= 5) begin
          iv = 1'b1; iop = 2'b10; ifn = F_MFLO;
        end
        drive(iv, iop, ifn, $urandom, $urandom);
        exp_stall = iv && (iop == 2'b10) && is_hilo(ifn);
        #1;
        if (mode != 0) check_val("stall", stall_o, exp_stall);
        if (mode == 2 && i >= 5) check_val("mflo_rdsel", rdsel_o, 2'b10);
        @(negedge clk);
      end
      check_val("result", {hi_o, lo_o}, res);
      check_val("commit", {busy_o, done_o}, 2'b01);
      if (mode == 2) begin
        check_val("mflo_go", stall_o, 1'b0);
        check_val("mflo_sel", rdsel_o, 2'b10);
      end
      drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
      @(negedge clk);
      check_val("done_clr", {busy_o, done_o}, 2'b00);
      check_val("result_keep", {hi_o, lo_o}, res);
    end
    mh[idx] = res[63:32];
    ml[idx] = res[31:0];
  endtask

  function automatic logic [31:0] pick_opnd(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return m;
      3: return (w == 32) ? 32'h8000_0000 : 32'h0000_0080;
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    int done_cnt;
    logic [5:0] rf;
    logic [5:0] ops [6];
    ops[0] = F_MULT; ops[1] = F_MULTU; ops[2] = F_DIV;
    ops[3] = F_DIVU; ops[4] = F_MTHI;  ops[5] = F_MTLO;
    mh[0] = 32'd0; ml[0] = 32'd0; mh[1] = 32'd0; ml[1] = 32'd0;

    reset_n = 1'b0;
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check_val("rst_hilo", {hi, lo}, 64'd0);
    check_val("rst_flags", {busy, done, busy8, done8}, 4'b0000);
    check_val("rst_hilo8", {hi8, lo8}, 16'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Combinational decode over every aluop/funct pair
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        aluop = 2'(op);
        funct = 6'(f);
        #1;
        check_val("decode", {alucontrol, rdsel, illegal}, dec_model(2'(op), 6'(f)));
      end
    end
    aluop = 2'b10; funct = 6'b101010; #1;
    check_val("slt", {alucontrol, rdsel, illegal}, 7'b0111_00_0);
    funct = 6'b111111; #1;
    check_val("bad_funct", {alucontrol, illegal}, 5'b0000_1);
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    @(negedge clk);

    // Directed 32-bit cases
    sel8 = 1'b0;
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    check_val("mult_m3x7", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check_val("div_m7d2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(F_DIVU, 32'd7, 32'd0, 0);
    check_val("divu_by0", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check_val("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op(F_DIV, 32'hFFFF_FFF0, 32'd0, 0);
    check_val("div_by0", {hi, lo}, 64'hFFFF_FFF0_FFFF_FFFF);
    run_op(F_MULTU, $urandom, $urandom, 2);

    // Reset in the middle of a multiply
    drive(1'b1, 2'b10, F_MULT, $urandom, $urandom);
    @(negedge clk);
    drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_hilo", {hi, lo}, 64'd0);
    check_val("mid_rst_flags", {busy, done}, 2'b00);
    mh[0] = 32'd0; ml[0] = 32'd0; mh[1] = 32'd0; ml[1] = 32'd0;
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_cnt += int'(done) + int'(busy);
    end
    check_val("no_done", done_cnt, 0);
    run_op(F_MTLO, 32'h0000_1234, 32'd0, 0);
    check_val("mtlo_1234", {hi, lo}, 64'h0000_0000_0000_1234);

    // Randomized 32-bit sequence with interference while busy
    for (int n = 0; n < 30; n++) begin
      rf = ops[$urandom_range(0, 5)];
      run_op(rf, pick_opnd(32), pick_opnd(32), 1);
    end

    // 8-bit instance
    sel8 = 1'b1;
    run_op(F_MULTU, 32'h0000_00FF, 32'h0000_00FF, 0);
    check_val("multu8_ff", {hi8, lo8}, 16'hFE01);
    for (int n = 0; n < 20; n++) begin
      rf = ops[$urandom_range(0, 5)];
      run_op(rf, pick_opnd(8), pick_opnd(8), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
